// File: rtl/gpu_stencil_pkg.sv
// Shared types and helpers for the stencil buffer: fill FSM states and
// mask/merge helpers used by both the commit path and the read bypass.
package gpu_stencil_pkg;

    // Widest word the helpers operate on; callers cast to their own width.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    // All-ones mask covering the low `width` bits.
    function automatic logic [MAX_W-1:0] all_ones_mask(input int width);
        logic [MAX_W-1:0] m;
        m = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Bit-wise merge: masked bits come from data_word, the rest from old_word.
    function automatic logic [MAX_W-1:0] merge_word(input logic [MAX_W-1:0] old_word,
                                                    input logic [MAX_W-1:0] data_word,
                                                    input logic [MAX_W-1:0] mask);
        return (old_word & ~mask) | (data_word & mask);
    endfunction

endpackage

// File: rtl/gpu_stencil_ram.sv
// 1W1R word RAM with an extra read-modify read port. Both read ports are
// synchronous, hold their data when not enabled, and return the word being
// written in the same cycle (write-first).
module gpu_stencil_ram #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              rm_re_i,
    input  logic [ADDR_W-1:0] rm_addr_i,
    output logic [DATA_W-1:0] rm_data_o
);

    localparam int DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array write; contents are intentionally never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Main read port with write-first bypass.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            if (we_i && (waddr_i == raddr_i)) begin
                rdata_o <= wdata_i;
            end else begin
                rdata_o <= mem[raddr_i];
            end
        end
    end

    // Read-modify port with write-first bypass, feeds the masked-write merge.
    always_ff @(posedge clk_i) begin
        if (rm_re_i) begin
            if (we_i && (waddr_i == rm_addr_i)) begin
                rm_data_o <= wdata_i;
            end else begin
                rm_data_o <= mem[rm_addr_i];
            end
        end
    end

endmodule

// File: rtl/gpu_stencil_buffer.sv
// Stencil/mask store: coherent 1-cycle read port, full and masked (RMW)
// write port, and a fill engine that writes one word per cycle.
module gpu_stencil_buffer
    import gpu_stencil_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_mask_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    input  logic              fill_start_i,
    input  logic [ADDR_W-1:0] fill_base_i,
    input  logic [CNT_W-1:0]  fill_count_i,
    input  logic [DATA_W-1:0] fill_value_i,
    output logic              fill_busy_o,
    output logic              fill_done_o
);

    localparam logic [DATA_W-1:0] FULL_MASK = DATA_W'(all_ones_mask(DATA_W));

    fill_state_e       state_r, state_nxt_s;
    logic [ADDR_W-1:0] fill_addr_r;
    logic [CNT_W-1:0]  fill_rem_r;
    logic [DATA_W-1:0] fill_val_r;

    logic              rmw_pending_r;
    logic [ADDR_W-1:0] rmw_addr_r;
    logic [DATA_W-1:0] rmw_data_r;
    logic [DATA_W-1:0] rmw_mask_r;

    logic              rd_valid_r;
    logic              rd_merge_r;
    logic [DATA_W-1:0] rd_hold_r;
    logic [DATA_W-1:0] rd_cur_s;

    logic              wr_accept_s;
    logic              wr_masked_s;
    logic              fill_start_ok_s;

    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic [DATA_W-1:0] rm_data_s;
    logic [DATA_W-1:0] commit_word_s;

    assign fill_busy_o   = (state_r != IDLE);
    assign fill_done_o   = (state_r == DONE);
    assign wr_ready_o    = !rmw_pending_r && !fill_busy_o;
    assign wr_accept_s   = wr_req_i && wr_ready_o;
    assign wr_masked_s   = wr_accept_s && (wr_mask_i != FULL_MASK);
    // A fill starting alongside a fresh masked write would collide with its
    // commit next cycle, so it waits like it does behind a pending commit.
    assign fill_start_ok_s = fill_start_i && (state_r == IDLE) && !rmw_pending_r && !wr_masked_s;

    assign commit_word_s = DATA_W'(merge_word(MAX_W'(rm_data_s), MAX_W'(rmw_data_r), MAX_W'(rmw_mask_r)));
    assign rd_data_o     = rd_valid_r ? rd_cur_s : rd_hold_r;

    gpu_stencil_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i     (clk_i),
        .we_i      (ram_we_s),
        .waddr_i   (ram_waddr_s),
        .wdata_i   (ram_wdata_s),
        .re_i      (rd_req_i),
        .raddr_i   (rd_addr_i),
        .rdata_o   (ram_rdata_s),
        .rm_re_i   (wr_masked_s),
        .rm_addr_i (wr_addr_i),
        .rm_data_o (rm_data_s)
    );

    // Fill FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fill FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fill_start_ok_s) begin
                    if (fill_count_i != {CNT_W{1'b0}}) begin
                        state_nxt_s = FILL;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (fill_rem_r == CNT_W'(1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Fill address/count/value: latched on start, stepped once per fill word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_addr_r <= {ADDR_W{1'b0}};
            fill_rem_r  <= {CNT_W{1'b0}};
            fill_val_r  <= {DATA_W{1'b0}};
        end else if (fill_start_ok_s) begin
            fill_addr_r <= fill_base_i;
            fill_rem_r  <= fill_count_i;
            fill_val_r  <= fill_value_i;
        end else if (state_r == FILL) begin
            fill_addr_r <= fill_addr_r + ADDR_W'(1);
            fill_rem_r  <= fill_rem_r - CNT_W'(1);
        end
    end

    // Masked write capture: the merge is committed in the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rmw_pending_r <= 1'b0;
            rmw_addr_r    <= {ADDR_W{1'b0}};
            rmw_data_r    <= {DATA_W{1'b0}};
            rmw_mask_r    <= {DATA_W{1'b0}};
        end else begin
            rmw_pending_r <= wr_masked_s;
            if (wr_masked_s) begin
                rmw_addr_r <= wr_addr_i;
                rmw_data_r <= wr_data_i;
                rmw_mask_r <= wr_mask_i;
            end
        end
    end

    // Write port mux: RMW commit, then fill word, then a new full write.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = {ADDR_W{1'b0}};
        ram_wdata_s = {DATA_W{1'b0}};
        if (rmw_pending_r) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = rmw_addr_r;
            ram_wdata_s = commit_word_s;
        end else if (state_r == FILL) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = fill_addr_r;
            ram_wdata_s = fill_val_r;
        end else if (wr_accept_s && !wr_masked_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = wr_addr_i;
            ram_wdata_s = wr_data_i;
        end else begin
            ram_we_s    = 1'b0;
        end
    end

    // Read-side tracking: valid delay, same-cycle masked-write hit, held data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_r <= 1'b0;
            rd_merge_r <= 1'b0;
            rd_hold_r  <= {DATA_W{1'b0}};
        end else begin
            rd_valid_r <= rd_req_i;
            if (rd_req_i) begin
                rd_merge_r <= wr_masked_s && (wr_addr_i == rd_addr_i);
            end
            if (rd_valid_r) begin
                rd_hold_r <= rd_cur_s;
            end
        end
    end

    // A read racing a just-accepted masked write to the same word sees the
    // merged result; the RM port read that word in the same cycle.
    always_comb begin
        rd_cur_s = ram_rdata_s;
        if (rd_merge_r) begin
            rd_cur_s = commit_word_s;
        end else begin
            rd_cur_s = ram_rdata_s;
        end
    end

    assign rd_valid_o = rd_valid_r;

endmodule

// File: tb/tb_gpu_stencil_buffer.sv
// Randomized scoreboard bench for gpu_stencil_buffer with a word-level model.
module tb_gpu_stencil_buffer;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [CNT_W-1:0]  fill_count;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;

    always #5 clk = ~clk;

    gpu_stencil_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_mask_i(wr_mask), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready),
        .fill_start_i(fill_start), .fill_base_i(fill_base), .fill_count_i(fill_count),
        .fill_value_i(fill_value), .fill_busy_o(fill_busy), .fill_done_o(fill_done)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc_cnt = 0;
    exp_t exp_q[$];
    logic [DATA_W-1:0] last_exp = 16'h0000;

    // Reference model: word memory plus fill/RMW bookkeeping in plain terms.
    logic [DATA_W-1:0] mem [int];
    int                m_rem = 0;
    bit                m_done = 1'b0;
    bit                m_pend = 1'b0;
    logic [ADDR_W-1:0] m_faddr = 15'h0;
    logic [DATA_W-1:0] m_fval = 16'h0;
    logic [ADDR_W-1:0] last_wa = 15'h0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: pops an expected read result whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_exp = 16'h0000;
        end else if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got valid data %h with nothing expected", rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                last_exp = e.data;
                check("rd_data", rd_data, e.data);
                check("rd_latency", cyc_cnt, e.cyc + 1);
            end
        end else begin
            check("rd_hold", rd_data, last_exp);
            if (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc_cnt) begin
                checks++;
                failures++;
                $display("FAIL rd_missing: got no valid, expected data %h", exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [ADDR_W-1:0] pool_addr();
        int r;
        r = $urandom_range(0, 79);
        if (r < 64) return ADDR_W'(r);
        else        return ADDR_W'(32'h7FF0 + r - 64);
    endfunction

    // One clock cycle: check status against the model, drive, update model.
    task automatic cycle(input bit rd, input logic [ADDR_W-1:0] ra,
                         input bit wr, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wm, input logic [DATA_W-1:0] wd,
                         input bit fs, input logic [ADDR_W-1:0] fb,
                         input logic [CNT_W-1:0] fc, input logic [DATA_W-1:0] fv);
        bit e_busy, e_ready, n_done, n_pend;
        int n_rem;
        e_busy  = (m_rem != 0) || m_done;
        e_ready = !m_pend && !e_busy;
        check("wr_ready", wr_ready, e_ready);
        check("fill_busy", fill_busy, e_busy);
        check("fill_done", fill_done, m_done);
        rd_req = rd; rd_addr = ra;
        wr_req = wr; wr_addr = wa; wr_mask = wm; wr_data = wd;
        fill_start = fs; fill_base = fb; fill_count = fc; fill_value = fv;
        n_rem = m_rem; n_done = 1'b0; n_pend = 1'b0;
        if (m_rem != 0) begin
            mem[int'(m_faddr)] = m_fval;
            m_faddr = m_faddr + 15'd1;
            n_rem = m_rem - 1;
            n_done = (n_rem == 0);
        end else if (!m_done && fs && !m_pend) begin
            m_faddr = fb;
            m_fval = fv;
            if (fc == 16'd0) n_done = 1'b1;
            else             n_rem = int'(fc);
        end
        if (wr && e_ready) begin
            mem[int'(wa)] = (mem[int'(wa)] & ~wm) | (wd & wm);
            n_pend = (wm != 16'hFFFF);
        end
        if (rd) exp_q.push_back('{mem[int'(ra)], cyc_cnt});
        m_rem = n_rem; m_done = n_done; m_pend = n_pend;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 15'h0, 1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 15'h0, 16'h0, 16'h0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        cycle(1'b1, a, 1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 15'h0, 16'h0, 16'h0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] d);
        cycle(1'b0, 15'h0, 1'b1, a, m, d, 1'b0, 15'h0, 16'h0, 16'h0);
    endtask

    task automatic settle();
        int guard;
        guard = 0;
        while ((m_rem != 0 || m_done || m_pend) && guard < 200) begin
            idle();
            guard++;
        end
        check("settle_timeout", guard < 200, 1'b1);
    endtask

    task automatic run_fill(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] v);
        cycle(1'b0, 15'h0, 1'b0, 15'h0, 16'h0, 16'h0, 1'b1, b, c, v);
        settle();
    endtask

    initial begin
        rst_n = 1'b0;
        rd_req = 1'b0; rd_addr = 15'h0; wr_req = 1'b0; wr_addr = 15'h0;
        wr_mask = 16'h0; wr_data = 16'h0; fill_start = 1'b0; fill_base = 15'h0;
        fill_count = 16'h0; fill_value = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_rd_data", rd_data, 16'h0000);
        rst_n = 1'b1;
        #1;

        // Known contents for every address the bench reads.
        run_fill(15'h0000, 16'd64, 16'h0000);
        run_fill(15'h7FF0, 16'd16, 16'h0F0F);
        run_fill(15'h0100, 16'd8, 16'h1111);

        // Full write then read next cycle.
        wr(15'h0010, 16'hFFFF, 16'hBEEF);
        rd(15'h0010);
        idle();

        // Masked RMW, read in the commit cycle and later.
        wr(15'h0020, 16'hFFFF, 16'h1234);
        wr(15'h0020, 16'h00F0, 16'h00FF);
        rd(15'h0020);
        idle();
        rd(15'h0020);

        // Back-to-back masked writes to one word compose.
        wr(15'h0005, 16'hFFFF, 16'h0000);
        wr(15'h0005, 16'h000F, 16'hFFFF);
        idle();
        wr(15'h0005, 16'hF000, 16'hAAAA);
        idle();
        rd(15'h0005);

        // Read racing a masked write to the same word.
        cycle(1'b1, 15'h0021, 1'b1, 15'h0021, 16'hFF00, 16'hABCD, 1'b0, 15'h0, 16'h0, 16'h0);
        idle();

        // Fill that wraps the top of the address space.
        run_fill(15'h7FFE, 16'd4, 16'h5A5A);
        rd(15'h7FFE); rd(15'h7FFF); rd(15'h0000); rd(15'h0001); rd(15'h0002);

        // Zero-length fill, and a start request held during an active fill.
        run_fill(15'h0040, 16'd0, 16'hFFFF);
        cycle(1'b0, 15'h0, 1'b0, 15'h0, 16'h0, 16'h0, 1'b1, 15'h0030, 16'd3, 16'h7777);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 15'h0, 1'b0, 15'h0, 16'h0, 16'h0, 1'b1, 15'h0038, 16'd2, 16'h0001);
        settle();
        for (int i = 0; i < 10; i++) rd(ADDR_W'(32'h30 + i));

        // Fill start during a pending commit waits for the commit.
        wr(15'h003A, 16'h00FF, 16'h0012);
        cycle(1'b0, 15'h0, 1'b0, 15'h0, 16'h0, 16'h0, 1'b1, 15'h003B, 16'd1, 16'h9999);
        cycle(1'b0, 15'h0, 1'b0, 15'h0, 16'h0, 16'h0, 1'b1, 15'h003B, 16'd1, 16'h9999);
        settle();
        rd(15'h003B); rd(15'h003A);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit r_rd, r_wr, r_fs;
            logic [ADDR_W-1:0] r_ra, r_wa, r_fb;
            logic [DATA_W-1:0] r_wm, r_wd, r_fv;
            logic [CNT_W-1:0]  r_fc;
            r_rd = ($urandom_range(0, 99) < 50);
            r_ra = ($urandom_range(0, 3) == 0) ? last_wa : pool_addr();
            r_fs = ($urandom_range(0, 99) < 4);
            r_wr = !r_fs && ($urandom_range(0, 99) < 60);
            r_wa = ($urandom_range(0, 2) == 0) ? last_wa : pool_addr();
            r_wm = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom());
            r_wd = 16'($urandom());
            r_fb = pool_addr();
            r_fc = 16'($urandom_range(0, 6));
            r_fv = 16'($urandom());
            cycle(r_rd, r_ra, r_wr, r_wa, r_wm, r_wd, r_fs, r_fb, r_fc, r_fv);
            if (r_wr) last_wa = r_wa;
        end
        settle();
        idle(); idle();

        // Reset part-way through an 8-word fill.
        cycle(1'b0, 15'h0, 1'b0, 15'h0, 16'h0, 16'h0, 1'b1, 15'h0100, 16'd8, 16'h2222);
        idle(); idle(); idle();
        rst_n = 1'b0;
        #1;
        check("midreset_wr_ready", wr_ready, 1'b1);
        check("midreset_fill_busy", fill_busy, 1'b0);
        check("midreset_fill_done", fill_done, 1'b0);
        check("midreset_rd_valid", rd_valid, 1'b0);
        check("midreset_rd_data", rd_data, 16'h0000);
        m_rem = 0; m_done = 1'b0; m_pend = 1'b0;
        @(posedge clk); @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) rd(ADDR_W'(32'h100 + i));
        idle(); idle(); idle();
        check("rd_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
